imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_load_dp.sv | 56 +++++
 rtl/imem_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the byte-stream instruction-memory boot loader.
// State encoding, frame header default and datapath widths.
package imem_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

endpackage

// File: rtl/imem_load_dp.sv
// Loader datapath: word count, address counter, big-endian word assembler
// and modulo-256 checksum accumulator, driven by strobes from the FSM.
module imem_load_dp
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              load_len,
    input  logic              take_hi,
    input  logic              take_lo,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] wdata,
    output logic [BYTE_W-1:0] sum,
    output logic              last
);

    logic [BYTE_W-1:0] len;
    logic [BYTE_W-1:0] hi;
    logic [ADDR_W-1:0] addr_next;

    assign addr_next = addr + 1'b1;
    // The word just written is the final one when the next address reaches LEN.
    assign last      = (addr_next == ADDR_W'(len));

    always_ff @(posedge clk) begin
        if (clear) begin
            len   <= '0;
            hi    <= '0;
            sum   <= '0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            if (load_len) begin
                len  <= rx_data;
                sum  <= rx_data;
                addr <= '0;
            end
            if (take_hi) begin
                hi  <= rx_data;
                sum <= sum + rx_data;
            end
            if (take_lo) begin
                wdata <= {hi, rx_data};
                sum   <= sum + rx_data;
            end
            if (advance) begin
                addr <= addr_next;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed boot loader: HEADER, LEN, 2*LEN data bytes, CSUM. Writes words to
// instruction memory from address 0 and holds the CPU until a frame verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [7:0]  HEADER = HEADER_DEFAULT,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              im_we,
    output logic              cpu_nClear,
    output logic              done,
    output logic              error
);

    state_t      state;
    state_t      state_next;
    logic        xfer;
    logic        load_len;
    logic        take_hi;
    logic        take_lo;
    logic        advance;
    logic        last;
    logic [7:0]  sum;

    assign rx_ready = !clear && (state != S_WRITE);
    assign xfer     = rx_valid && rx_ready;

    imem_load_dp #(
        .ADDR_W(ADDR_W)
    ) u_dp (
        .clk      (clk),
        .clear    (clear),
        .rx_data  (rx_data),
        .load_len (load_len),
        .take_hi  (take_hi),
        .take_lo  (take_lo),
        .advance  (advance),
        .addr     (im_addr),
        .wdata    (im_wdata),
        .sum      (sum),
        .last     (last)
    );

    always_comb begin
        state_next = state;
        load_len   = 1'b0;
        take_hi    = 1'b0;
        take_lo    = 1'b0;
        advance    = 1'b0;
        unique case (state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (xfer && rx_data == HEADER) state_next = S_LEN;
            end
            S_LEN: begin
                if (xfer) begin
                    load_len   = 1'b1;
                    state_next = (rx_data == 8'd0) ? S_ERROR : S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    take_hi    = 1'b1;
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    take_lo    = 1'b1;
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                advance    = 1'b1;
                state_next = last ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                if (xfer) state_next = (rx_data == sum) ? S_RUN : S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they track the state exactly.
    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= S_IDLE;
            im_we      <= 1'b0;
            cpu_nClear <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_next;
            im_we      <= (state_next == S_WRITE);
            cpu_nClear <= (state_next == S_RUN);
            done       <= (state_next == S_RUN);
            error      <= (state_next == S_ERROR);
        end
    end

endmodule
